// File: rtl/kbd_char_sequencer.sv
// kbd_char_sequencer
//   Frames bytes from the PS/2 receiver (make, break and extended prefixes),
//   presents single-byte make codes to the scan-code-to-ASCII translator,
//   waits out the translator's one-cycle registered latency, drops unmapped
//   results (8'h2A) and buffers characters in a show-ahead FIFO.
//
// Parameters
//   FIFO_DEPTH  character FIFO entries (power of two, 2..16)
//   REPEAT_EN   1: pass typematic repeats; 0: suppress repeats of the held key
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   rx_data       byte from PS/2 receiver, valid with rx_done_tick
//   rx_done_tick  one-cycle strobe for rx_data
//   key_code      registered scan code to the translator
//   ascii_code    translator result, valid one cycle after key_code changes
//   char_data     FIFO head (show-ahead), meaningful while char_valid
//   char_valid    FIFO not empty
//   char_ready    consumer accepts head when char_valid & char_ready
//   overflow      one-cycle pulse: character dropped, FIFO full
//   busy          lookup in progress (LOOK1/LOOK2)
module kbd_char_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic [7:0] key_code,
  input  logic [7:0] ascii_code,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] UNMAPPED     = 8'h2A;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    LOOK1,
    LOOK2
  } state_t;

  state_t      state_reg;
  logic [7:0]  key_code_reg;
  logic [7:0]  held_reg;
  logic        busy_reg;
  logic        overflow_reg;

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [7:0]  mem_reg [FIFO_DEPTH];

  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        push_req;
  logic        push_ok;
  logic        pop;

  // ---------------------------------------------------------------------------
  // Framing / lookup sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      key_code_reg <= 8'h00;
      held_reg     <= 8'h00;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_done_tick) begin
            if (rx_data == BREAK_PREFIX) begin
              state_reg <= BRK;
            end else if (rx_data == EXT_PREFIX) begin
              state_reg <= EXT;
            end else if (!REPEAT_EN && (rx_data == held_reg)) begin
              // typematic repeat of the key still held down: drop it
              state_reg <= IDLE;
            end else begin
              key_code_reg <= rx_data;
              held_reg     <= rx_data;
              busy_reg     <= 1'b1;
              state_reg    <= LOOK1;
            end
          end
        end
        BRK: begin
          if (rx_done_tick) begin
            if (rx_data == held_reg) begin
              held_reg <= 8'h00;
            end
            state_reg <= IDLE;
          end
        end
        EXT: begin
          if (rx_done_tick) begin
            state_reg <= (rx_data == BREAK_PREFIX) ? EXT_BRK : IDLE;
          end
        end
        EXT_BRK: begin
          if (rx_done_tick) begin
            state_reg <= IDLE;
          end
        end
        LOOK1: begin
          // translator is registering key_code this cycle
          state_reg <= LOOK2;
        end
        LOOK2: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Character FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign push_req = (state_reg == LOOK2) && (ascii_code != UNMAPPED);
  assign pop      = !empty && char_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push_req && full && !pop;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= ascii_code;
    end
  end

  assign key_code   = key_code_reg;
  assign busy       = busy_reg;
  assign overflow   = overflow_reg;
  assign char_valid = !empty;
  assign char_data  = empty ? 8'h00 : mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: tb/tb_kbd_char_sequencer.sv
// tb_kbd_char_sequencer
//   Table-driven check of framing/lookup plus hand-written sequences for
//   reset, FIFO full/overflow, simultaneous push/pop, pointer wrap and
//   repeat suppression. A behavioural registered translator feeds ascii_code.
module tb_kbd_char_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       char_ready;
  logic       char_ready0;
  logic [7:0] ascii_code;
  logic [7:0] ascii0;

  logic [7:0] key_code, char_data, key0, data0;
  logic       char_valid, overflow, busy, valid0, ov0, busy0;

  always #5 clk = ~clk;

  // repeats passed
  kbd_char_sequencer #(.FIFO_DEPTH(4), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .key_code(key_code), .ascii_code(ascii_code), .char_data(char_data),
    .char_valid(char_valid), .char_ready(char_ready), .overflow(overflow),
    .busy(busy)
  );

  // repeats suppressed, always drained
  kbd_char_sequencer #(.FIFO_DEPTH(4), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .key_code(key0), .ascii_code(ascii0), .char_data(data0),
    .char_valid(valid0), .char_ready(char_ready0), .overflow(ov0),
    .busy(busy0)
  );

  function automatic logic [7:0] xlate(input logic [7:0] k);
    case (k)
      8'h1C: xlate = 8'h41;
      8'h29: xlate = 8'h20;
      8'h16: xlate = 8'h31;
      8'h45: xlate = 8'h30;
      8'h1E: xlate = 8'h32;
      8'h26: xlate = 8'h33;
      8'h25: xlate = 8'h34;
      default: xlate = 8'h2A;
    endcase
  endfunction

  // translator model: one-cycle registered lookup
  always @(posedge clk) begin
    ascii_code <= xlate(key_code);
    ascii0     <= xlate(key0);
  end

  // consumer monitors
  logic [7:0] got[$];
  logic [7:0] got0[$];
  int         ov_cnt = 0;
  always @(negedge clk) begin
    if (char_valid && char_ready) got.push_back(char_data);
    if (valid0 && char_ready0) got0.push_back(data0);
    if (overflow) ov_cnt++;
  end

  int n_chk  = 0;
  int n_fail = 0;
  bit rnd_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_en) char_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic strobe(input logic [7:0] b);
    step();
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  // send one byte, sample busy at t+1..t+3 and results at t+3, overflow at t+4
  task automatic send_look(input logic [7:0] b,
                           output logic b1, output logic b2, output logic b3,
                           output logic v3, output logic o3, output logic o4,
                           output logic [7:0] d3, output logic [7:0] k3);
    strobe(b);
    @(negedge clk); b1 = busy;
    @(negedge clk); b2 = busy;
    @(negedge clk); b3 = busy; v3 = char_valid; d3 = char_data;
                    k3 = key_code; o3 = overflow;
    @(negedge clk); o4 = overflow;
  endtask

  typedef struct {
    logic [7:0] rx;
    logic       bsy;
    logic       vld;
    logic [7:0] ch;
    logic [7:0] key;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] fill[5];
  logic [7:0] expc[5];
  logic [7:0] rep[6];
  logic       b1, b2, b3, v3, o3, o4;
  logic [7:0] d3, k3;
  int         base, base0, sent, w, ovb;

  // drain four entries with char_ready held high, checking order
  task automatic drain4(input int first);
    step();
    char_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", 32'(char_valid), 32'd1);
      chk("drain_data", 32'(char_data), 32'(expc[first + i]));
      step();
    end
    char_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", 32'(char_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h1C, 1'b1, 1'b1, 8'h41, 8'h1C};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[4]  = '{8'h75, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[7]  = '{8'h75, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[9]  = '{8'h29, 1'b0, 1'b0, 8'h00, 8'h1C};
    tbl[10] = '{8'h29, 1'b1, 1'b1, 8'h20, 8'h29};
    tbl[11] = '{8'h05, 1'b1, 1'b0, 8'h00, 8'h05};
    fill = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25};
    expc = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    rep  = '{8'h16, 8'h16, 8'h16, 8'hF0, 8'h16, 8'h16};

    // ---- reset with rx_done_tick toggling ----
    rst_n        = 1'b0;
    rx_data      = 8'h1C;
    rx_done_tick = 1'b0;
    char_ready   = 1'b0;
    char_ready0  = 1'b1;
    step(); rx_done_tick = 1'b1;
    step(); rx_done_tick = 1'b0;
    @(negedge clk);
    chk("rst_key", 32'(key_code), 32'h00);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_data", 32'(char_data), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_key0", 32'(key0), 32'h00);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ovf0", 32'(ov0), 32'd0);
    step(); rst_n = 1'b1;

    // ---- table: framing, lookup, unmapped ----
    for (int i = 0; i < 12; i++) begin
      send_look(tbl[i].rx, b1, b2, b3, v3, o3, o4, d3, k3);
      $display("vec %0d: rx=%02h busy=%b%b%b valid=%b data=%02h key=%02h", i,
               tbl[i].rx, b1, b2, b3, v3, d3, k3);
      chk("tbl_busy1", 32'(b1), 32'(tbl[i].bsy));
      chk("tbl_busy2", 32'(b2), 32'(tbl[i].bsy));
      chk("tbl_busy3", 32'(b3), 32'd0);
      chk("tbl_valid", 32'(v3), 32'(tbl[i].vld));
      chk("tbl_key", 32'(k3), 32'(tbl[i].key));
      chk("tbl_ovf", 32'(o3), 32'd0);
      if (tbl[i].vld) begin
        chk("tbl_data", 32'(d3), 32'(tbl[i].ch));
        step(); char_ready = 1'b1;
        step(); char_ready = 1'b0;
        @(negedge clk);
        chk("tbl_popped", 32'(char_valid), 32'd0);
      end
    end

    // ---- reset in the middle of a lookup ----
    strobe(8'h1C);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_valid", 32'(char_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_key", 32'(key_code), 32'h00);
    $display("mid-lookup reset: valid=%b busy=%b key=%02h", char_valid, busy, key_code);

    // ---- FIFO full, fifth character dropped ----
    for (int i = 0; i < 5; i++) begin
      send_look(fill[i], b1, b2, b3, v3, o3, o4, d3, k3);
      $display("fill %0d: rx=%02h valid=%b head=%02h ovf=%b%b", i, fill[i], v3, d3, o3, o4);
      chk("full_ovf", 32'(o3), (i == 4) ? 32'd1 : 32'd0);
      chk("full_ovf_clear", 32'(o4), 32'd0);
      chk("full_head", 32'(d3), 32'h30);
    end
    drain4(0);

    // ---- push into full FIFO with simultaneous pop ----
    for (int i = 0; i < 4; i++) send_look(fill[i], b1, b2, b3, v3, o3, o4, d3, k3);
    strobe(8'h25);
    step(); char_ready = 1'b1;
    @(negedge clk);
    chk("pp_busy_look2", 32'(busy), 32'd1);
    step(); char_ready = 1'b0;
    @(negedge clk);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(char_data), 32'h31);
    $display("push/pop when full: ovf=%b head=%02h", overflow, char_data);
    drain4(1);

    // ---- pointer wrap, random consumer ----
    rnd_en = 1'b1;
    sent   = 0;
    base   = got.size();
    ovb    = ov_cnt;
    for (int i = 0; i < 20; i++) begin
      w = 0;
      while ((sent - (got.size() - base)) > 3 && w < 50) begin
        step();
        w++;
      end
      if (w >= 50) chk("wrap_throttle_timeout", 32'(w), 32'd0);
      strobe(fill[i % 5]);
      step(); step(); step();
      sent++;
    end
    rnd_en     = 1'b0;
    char_ready = 1'b1;
    w = 0;
    while ((got.size() - base) < 20 && w < 100) begin
      step();
      w++;
    end
    char_ready = 1'b0;
    chk("wrap_count", 32'(got.size() - base), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (base + i < got.size()) begin
        $display("wrap %0d: got=%02h expected=%02h", i, got[base + i], expc[i % 5]);
        chk("wrap_order", 32'(got[base + i]), 32'(expc[i % 5]));
      end
    end
    chk("wrap_no_ovf", 32'(ov_cnt - ovb), 32'd0);

    // ---- typematic repeat handling (both variants) ----
    rst_n = 1'b0;
    step(); step();
    rst_n      = 1'b1;
    char_ready = 1'b1;
    base       = got.size();
    base0      = got0.size();
    for (int i = 0; i < 6; i++) send_look(rep[i], b1, b2, b3, v3, o3, o4, d3, k3);
    step(); step();
    char_ready = 1'b0;
    $display("repeat: passed=%0d suppressed=%0d", got.size() - base, got0.size() - base0);
    chk("rep_en1_count", 32'(got.size() - base), 32'd4);
    chk("rep_en0_count", 32'(got0.size() - base0), 32'd2);
    for (int i = base; i < got.size(); i++) chk("rep_en1_char", 32'(got[i]), 32'h31);
    for (int i = base0; i < got0.size(); i++) chk("rep_en0_char", 32'(got0[i]), 32'h31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
